// File: rtl/cpu_bus_memory_if.sv
// CPU bus bundle between the CPU/host side and the memory responder: instruction port,
// data-port control and program loader. The tristate data bus DD is a plain port on the memory.
interface cpu_bus_memory_if;
  logic [15:0] IA;
  logic [15:0] ID;
  logic [15:0] DA;
  logic        RW;
  logic        CPU_RST;
  logic        LD_START;
  logic        LD_VALID;
  logic [7:0]  LD_BYTE;
  logic        LD_READY;
  logic        LD_DONE;
  logic        LD_OVF;
  logic [15:0] IO_OUT;

  modport master (
    output IA, DA, RW, LD_START, LD_VALID, LD_BYTE, LD_DONE,
    input  ID, CPU_RST, LD_READY, LD_OVF, IO_OUT
  );

  modport slave (
    input  IA, DA, RW, LD_START, LD_VALID, LD_BYTE, LD_DONE,
    output ID, CPU_RST, LD_READY, LD_OVF, IO_OUT
  );
endinterface

// File: rtl/cpu_bus_memory.sv
// Memory-side responder for the 16-bit CPU bus: instruction RAM, data RAM, one output register
// and a byte-serial program loader that holds the CPU in reset while it fills instruction RAM.
module cpu_bus_memory #(
  parameter int unsigned IAW     = 8,
  parameter int unsigned DAW     = 8,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic              CK,
  input  logic              RST,
  inout  wire  [15:0]       DD,
  cpu_bus_memory_if.slave   bus
);

  localparam int unsigned IWords = 2 ** IAW;
  localparam int unsigned DWords = 2 ** DAW;

  typedef enum logic [2:0] {StHold, StLoadHi, StLoadLo, StRelease, StRun} state_e;

  state_e           state_q, state_d;
  logic [IAW-1:0]   ptr_q, ptr_d;
  logic [7:0]       hi_q, hi_d;
  logic             ovf_q, ovf_d;
  logic             ld_ready_q, ld_ready_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic [15:0]      io_q, io_d;

  logic [15:0]      imem [IWords];
  logic [15:0]      dmem [DWords];

  logic             accept;
  logic             imem_we;
  logic [15:0]      imem_wdata;
  logic             ia_in_range, da_in_range;
  logic             run_wr;
  logic             dmem_we;
  logic [15:0]      rdata;

  assign accept = bus.LD_VALID && ld_ready_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hi_d       = hi_q;
    ovf_d      = ovf_q;
    imem_we    = 1'b0;
    imem_wdata = '0;
    case (state_q)
      StHold, StRun: begin
        if (bus.LD_START) begin
          state_d = StLoadHi;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StLoadHi: begin
        // A final byte arriving with DONE is an odd tail: pad its low byte.
        if (accept && bus.LD_DONE) begin
          imem_we    = 1'b1;
          imem_wdata = {bus.LD_BYTE, 8'h00};
          state_d    = StRelease;
        end else if (accept) begin
          hi_d    = bus.LD_BYTE;
          state_d = StLoadLo;
        end else if (bus.LD_DONE) begin
          state_d = StRelease;
        end
      end
      StLoadLo: begin
        if (accept) begin
          imem_we    = 1'b1;
          imem_wdata = {hi_q, bus.LD_BYTE};
          state_d    = bus.LD_DONE ? StRelease : StLoadHi;
        end else if (bus.LD_DONE) begin
          imem_we    = 1'b1;
          imem_wdata = {hi_q, 8'h00};
          state_d    = StRelease;
        end
      end
      StRelease: state_d = StRun;
      default:   state_d = StHold;
    endcase
    if (imem_we) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == '1) ovf_d = 1'b1;
    end
  end

  assign ld_ready_d = (state_d == StLoadHi) || (state_d == StLoadLo);
  assign cpu_rst_d  = (state_d != StRun);

  assign ia_in_range = (bus.IA >> IAW) == '0;
  assign da_in_range = (bus.DA >> DAW) == '0;
  assign run_wr      = (state_q == StRun) && !bus.RW;
  assign dmem_we     = run_wr && (bus.DA != IO_ADDR) && da_in_range;

  always_comb begin
    io_d = io_q;
    if (run_wr && (bus.DA == IO_ADDR)) io_d = DD;
  end

  // IO_ADDR wins over dmem when the ranges overlap.
  always_comb begin
    rdata = '0;
    if (bus.DA == IO_ADDR)  rdata = io_q;
    else if (da_in_range)   rdata = dmem[bus.DA[DAW-1:0]];
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= StHold;
      ptr_q      <= '0;
      hi_q       <= '0;
      ovf_q      <= 1'b0;
      ld_ready_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
      io_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hi_q       <= hi_d;
      ovf_q      <= ovf_d;
      ld_ready_q <= ld_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      io_q       <= io_d;
    end
  end

  always_ff @(posedge CK) begin
    if (!RST && imem_we) imem[ptr_q] <= imem_wdata;
    if (!RST && dmem_we) dmem[bus.DA[DAW-1:0]] <= DD;
  end

  assign DD = (bus.RW && (state_q == StRun)) ? rdata : 16'bz;

  assign bus.ID       = ia_in_range ? imem[bus.IA[IAW-1:0]] : 16'h0000;
  assign bus.CPU_RST  = cpu_rst_q;
  assign bus.LD_READY = ld_ready_q;
  assign bus.LD_OVF   = ovf_q;
  assign bus.IO_OUT   = io_q;

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Bench for cpu_bus_memory: directed loader/data/IO scenarios, then randomized traffic, all
// checked every cycle against a word-level model of the loader and memories.
module tb_cpu_bus_memory;
  localparam int unsigned IAW    = 2;
  localparam int unsigned DAW    = 8;
  localparam int          IMEM_W = 4;
  localparam int          DMEM_W = 256;
  localparam int MHold = 0, MLoad = 1, MRel = 2, MRun = 3;

  logic        CK = 1'b0;
  logic        RST;
  logic [15:0] tb_dd;
  wire  [15:0] dd;

  always #5 CK = ~CK;

  cpu_bus_memory_if bus ();

  assign dd = bus.RW ? 16'bz : tb_dd;

  cpu_bus_memory #(
    .IAW     (IAW),
    .DAW     (DAW),
    .IO_ADDR (16'hFFFF)
  ) dut (
    .CK  (CK),
    .RST (RST),
    .DD  (dd),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: byte count within the current load determines word slot and half.
  int          m_mode  = MHold;
  bit          m_valid = 1'b0;
  int          m_nb;
  logic [7:0]  m_hi;
  bit          m_ovf;
  logic [15:0] m_io;
  logic [15:0] m_imem [IMEM_W];
  bit          m_ik   [IMEM_W];
  logic [15:0] m_dmem [DMEM_W];
  bit          m_dk   [DMEM_W];

  task automatic put_word(input logic [15:0] w);
    int idx;
    idx = (m_nb / 2) % IMEM_W;
    m_imem[idx] = w;
    m_ik[idx]   = 1'b1;
    if (idx == IMEM_W - 1) m_ovf = 1'b1;
  endtask

  always @(posedge CK) begin
    if (RST) begin
      m_mode  = MHold;
      m_ovf   = 1'b0;
      m_io    = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_mode)
        MHold, MRun: begin
          if (m_mode == MRun && !bus.RW) begin
            if (bus.DA == 16'hFFFF) m_io = tb_dd;
            else if (bus.DA < 16'(DMEM_W)) begin
              m_dmem[bus.DA[7:0]] = tb_dd;
              m_dk[bus.DA[7:0]]   = 1'b1;
            end
          end
          if (bus.LD_START) begin
            m_mode = MLoad;
            m_nb   = 0;
            m_ovf  = 1'b0;
          end
        end
        MLoad: begin
          if (bus.LD_VALID) begin
            if (m_nb % 2 == 0) m_hi = bus.LD_BYTE;
            else put_word({m_hi, bus.LD_BYTE});
            m_nb++;
          end
          if (bus.LD_DONE) begin
            if (m_nb % 2 == 1) begin
              put_word({m_hi, 8'h00});
              m_nb++;
            end
            m_mode = MRel;
          end
        end
        default: m_mode = MRun;
      endcase
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge CK) begin
    if (m_valid && !RST) begin
      check("cpu_rst", 16'(bus.CPU_RST), 16'(m_mode != MRun));
      check("ld_ready", 16'(bus.LD_READY), 16'(m_mode == MLoad));
      check("ld_ovf", 16'(bus.LD_OVF), 16'(m_ovf));
      check("io_out", bus.IO_OUT, m_io);
      if (bus.IA >= 16'(IMEM_W)) check("id_oor", bus.ID, 16'h0000);
      else if (m_ik[bus.IA[1:0]]) check("id", bus.ID, m_imem[bus.IA[1:0]]);
      if (!bus.RW) check("dd_cpu_drive", dd, tb_dd);
      else if (m_mode == MRun) begin
        if (bus.DA == 16'hFFFF) check("dd_io", dd, m_io);
        else if (bus.DA >= 16'(DMEM_W)) check("dd_oor", dd, 16'h0000);
        else if (m_dk[bus.DA[7:0]]) check("dd_rd", dd, m_dmem[bus.DA[7:0]]);
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic ld_start();
    bus.LD_START = 1'b1;
    tick();
    bus.LD_START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic done);
    bus.LD_VALID = 1'b1;
    bus.LD_BYTE  = b;
    bus.LD_DONE  = done;
    tick();
    bus.LD_VALID = 1'b0;
    bus.LD_DONE  = 1'b0;
  endtask

  task automatic ld_done();
    bus.LD_DONE = 1'b1;
    tick();
    bus.LD_DONE = 1'b0;
  endtask

  task automatic peek_id(input logic [15:0] a, input string name, input logic [15:0] exp);
    bus.IA = a;
    #1;
    check(name, bus.ID, exp);
  endtask

  initial begin
    RST = 1'b1;
    bus.IA = '0; bus.DA = '0; bus.RW = 1'b1; tb_dd = '0;
    bus.LD_START = 1'b0; bus.LD_VALID = 1'b0; bus.LD_BYTE = '0; bus.LD_DONE = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    check("rst_cpu_rst", 16'(bus.CPU_RST), 16'h1);
    check("rst_ld_ready", 16'(bus.LD_READY), 16'h0);
    check("rst_io_out", bus.IO_OUT, 16'h0);
    check("rst_ld_ovf", 16'(bus.LD_OVF), 16'h0);

    // Even load, then release timing.
    ld_start();
    check("ready_after_start", 16'(bus.LD_READY), 16'h1);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0); send_byte(8'hCD, 1'b0);
    ld_done();
    check("release_cpu_rst", 16'(bus.CPU_RST), 16'h1);
    tick();
    check("run_cpu_rst", 16'(bus.CPU_RST), 16'h0);
    peek_id(16'd1, "load_word1", 16'hABCD);
    peek_id(16'd0, "load_word0", 16'h1234);
    check("model_word1", m_imem[1], 16'hABCD);

    // Odd loads: separate DONE, DONE with a high byte, DONE with a low byte.
    ld_start();
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b0);
    ld_done(); tick();
    peek_id(16'd1, "odd_pad", 16'h7700);
    peek_id(16'd0, "odd_word0", 16'h5566);
    ld_start();
    send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b1);
    tick();
    peek_id(16'd1, "done_with_hi", 16'h0300);
    ld_start();
    send_byte(8'h0A, 1'b0); send_byte(8'h0B, 1'b0);
    send_byte(8'h0C, 1'b0); send_byte(8'h0D, 1'b1);
    tick();
    peek_id(16'd1, "done_with_lo", 16'h0C0D);
    peek_id(16'd5, "id_out_of_range", 16'h0000);

    // Data port and IO register.
    bus.RW = 1'b0; bus.DA = 16'd5; tb_dd = 16'hBEEF;
    tick();
    bus.RW = 1'b1;
    #1 check("dmem_rd", dd, 16'hBEEF);
    bus.DA = 16'h0100;
    #1 check("dmem_oor", dd, 16'h0000);
    bus.RW = 1'b0; bus.DA = 16'hFFFF; tb_dd = 16'h00A5;
    tick();
    check("io_write", bus.IO_OUT, 16'h00A5);
    bus.RW = 1'b1;
    #1 check("io_rd", dd, 16'h00A5);

    // Wrap past the last word, then abort a load with reset.
    ld_start();
    for (int w = 1; w <= 5; w++) begin
      send_byte(8'(w * 8'h11), 1'b0);
      send_byte(8'(w * 8'h11), 1'b0);
    end
    check("wrap_ovf", 16'(bus.LD_OVF), 16'h1);
    ld_done(); tick();
    peek_id(16'd0, "wrap_word0", 16'h5555);
    ld_start();
    check("start_clears_ovf", 16'(bus.LD_OVF), 16'h0);
    send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0); send_byte(8'h99, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_ld_ready", 16'(bus.LD_READY), 16'h0);
    check("abort_cpu_rst", 16'(bus.CPU_RST), 16'h1);
    peek_id(16'd0, "abort_retained", 16'h7788);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.LD_START = 1'b0; bus.LD_VALID = 1'b0; bus.LD_DONE = 1'b0;
      bus.IA = 16'($urandom_range(0, 7));
      RST = ($urandom_range(0, 299) == 0);
      case (m_mode)
        MHold: bus.LD_START = ($urandom_range(0, 3) == 0);
        MLoad: begin
          bus.LD_VALID = ($urandom_range(0, 2) != 0);
          bus.LD_BYTE  = 8'($urandom);
          bus.LD_DONE  = ($urandom_range(0, 11) == 0);
          bus.LD_START = ($urandom_range(0, 9) == 0);
        end
        MRun: begin
          bus.RW = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 3))
            0:       bus.DA = 16'hFFFF;
            1:       bus.DA = 16'h0100 + 16'($urandom_range(0, 255));
            default: bus.DA = 16'($urandom_range(0, 15));
          endcase
          tb_dd = 16'($urandom);
          bus.LD_START = ($urandom_range(0, 59) == 0);
        end
        default: ;
      endcase
      tick();
    end
    RST = 1'b0;
    bus.LD_START = 1'b0; bus.LD_VALID = 1'b0; bus.LD_DONE = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
